// File: rtl/mimo_enq_arbiter.sv
// mimo_enq_arbiter: shares one width-up MIMO enq port between numReq requesters.
// A grant is held for one full MIMO output word (BEATS input beats) so every
// output word comes from a single source; words are granted round-robin.
//
// Optional build macro MIMO_ARB_PRIO0_EN: requester 0 gets strict priority at
// arbitration time and its words do not move the round-robin pointer.
//
// FSM states:
//   S_IDLE   | no owner; arbitrate among req_want, all RDY low (one bubble cycle)
//   S_LOCKED | owner gnt_q streams BEATS beats straight through to the MIMO
module mimo_enq_arbiter #(
  parameter int numReq   = 4,
  parameter int widthIn  = 32,
  parameter int widthOut = 128
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [numReq-1:0]           req_want,
  input  logic [numReq-1:0]           req_enq__ENA,
  input  logic [numReq*widthIn-1:0]   req_enq_v,
  output logic [numReq-1:0]           req_enq__RDY,
  output logic                        mimo_enq__ENA,
  output logic [widthIn-1:0]          mimo_enq_v,
  input  logic                        mimo_enq__RDY,
  output logic [((numReq > 1) ? $clog2(numReq) : 1)-1:0] owner,
  output logic                        owner__VALID
);

  localparam int BEATS = widthOut / widthIn;
  localparam int IDW   = (numReq > 1) ? $clog2(numReq) : 1;
  localparam int CW    = $clog2(BEATS + 1);

  // Reject geometries where an output word is not a whole number of beats.
  generate
    if ((widthOut < widthIn) || ((widthOut % widthIn) != 0)) begin : g_bad_width
      $error("mimo_enq_arbiter: widthOut must be a positive integer multiple of widthIn");
    end
    if ((numReq < 1) || (numReq > 16)) begin : g_bad_numreq
      $error("mimo_enq_arbiter: numReq must be in 1..16");
    end
  endgenerate

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic             beat_acc;
  logic [IDW-1:0]   ptr_after_gnt;

  // Winner search: first requester wanting a word, starting at ptr_q and wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < numReq; k++) begin
      if (!win_found && req_want[(int'(ptr_q) + k) % numReq]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr_q) + k) % numReq);
      end
    end
`ifdef MIMO_ARB_PRIO0_EN
    if (req_want[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  // A beat moves only when the owner strobes and the MIMO can take it; the
  // owner's ENA is already qualified by its RDY, so no ENA->RDY path exists.
  assign beat_acc = (state_q == S_LOCKED) && req_enq__ENA[gnt_q] && mimo_enq__RDY;

  assign ptr_after_gnt = (int'(gnt_q) == numReq - 1) ? '0 : IDW'(gnt_q + 1'b1);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: lock on a winner, release after the last beat of the word.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_LOCKED;
          gnt_d   = win_idx;
          cnt_d   = '0;
        end
      end
      S_LOCKED: begin
        if (beat_acc) begin
          if (cnt_q == CW'(BEATS - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef MIMO_ARB_PRIO0_EN
            if (gnt_q != '0) ptr_d = ptr_after_gnt;
`else
            ptr_d = ptr_after_gnt;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: only the owner sees RDY, and its beats pass through with no delay.
  always_comb begin
    req_enq__RDY  = '0;
    mimo_enq__ENA = 1'b0;
    owner         = '0;
    owner__VALID  = 1'b0;
    mimo_enq_v    = req_enq_v[int'(gnt_q)*widthIn +: widthIn];
    if (state_q == S_LOCKED) begin
      req_enq__RDY[gnt_q] = mimo_enq__RDY;
      mimo_enq__ENA       = beat_acc;
      owner               = gnt_q;
      owner__VALID        = 1'b1;
    end
  end

endmodule

// File: tb/tb_mimo_enq_arbiter.sv
// Self-checking bench for mimo_enq_arbiter (numReq=4, widthIn=32, widthOut=128).
// A word-level reference model (owner, beats so far, round-robin pointer)
// predicts every output each cycle; directed scenarios add grant-order checks.
module tb_mimo_enq_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int WOUT  = 128;
  localparam int BEATS = WOUT / W;

  logic             CLK = 1'b0;
  logic             RST;
  logic [N-1:0]     req_want;
  logic [N-1:0]     req_enq__ENA;
  logic [N*W-1:0]   req_enq_v;
  logic [N-1:0]     req_enq__RDY;
  logic             mimo_enq__ENA;
  logic [W-1:0]     mimo_enq_v;
  logic             mimo_enq__RDY;
  logic [1:0]       owner;
  logic             owner__VALID;

  mimo_enq_arbiter #(.numReq(N), .widthIn(W), .widthOut(WOUT)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_want      (req_want),
    .req_enq__ENA  (req_enq__ENA),
    .req_enq_v     (req_enq_v),
    .req_enq__RDY  (req_enq__RDY),
    .mimo_enq__ENA (mimo_enq__ENA),
    .mimo_enq_v    (mimo_enq_v),
    .mimo_enq__RDY (mimo_enq__RDY),
    .owner         (owner),
    .owner__VALID  (owner__VALID)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port, how many beats of the word have gone,
  // and which requester is first in line at the next arbitration.
  bit m_locked;
  int m_owner;
  int m_beats;
  int m_ptr;

  int       grant_log[$];
  logic [W-1:0] data_log[$];
  bit       prev_valid;

  function automatic int pick_winner(input logic [N-1:0] want);
    int order[$];
`ifdef MIMO_ARB_PRIO0_EN
    if (want[0]) return 0;
`endif
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[j]) if (want[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  // One clock cycle: drive inputs at negedge, strobe ENA only where RDY is
  // offered, compare outputs against the model, then advance the model.
  task automatic step(input bit rst, input logic [N-1:0] want, input logic [N-1:0] ena_req,
                      input bit mrdy, input logic [N*W-1:0] data, output bit accepted);
    logic [N-1:0] exp_rdy;
    bit           exp_ena;
    int           w;
    @(negedge CLK);
    RST           = rst;
    req_want      = want;
    mimo_enq__RDY = mrdy;
    req_enq_v     = data;
    req_enq__ENA  = '0;
    #1;
    req_enq__ENA  = ena_req & req_enq__RDY;
    #1;
    exp_rdy = (m_locked && mrdy) ? N'(1 << m_owner) : '0;
    exp_ena = m_locked && mrdy && req_enq__ENA[m_owner];
    chk("req_rdy", req_enq__RDY, exp_rdy);
    chk("mimo_ena", mimo_enq__ENA, exp_ena);
    chk("owner_valid", owner__VALID, m_locked);
    chk("owner", owner, m_locked ? m_owner : 0);
    if (exp_ena) chk("mimo_data", mimo_enq_v, data[m_owner*W +: W]);
    if (mimo_enq__ENA) data_log.push_back(mimo_enq_v);
    if (owner__VALID && !prev_valid) grant_log.push_back(int'(owner));
    prev_valid = owner__VALID;
    accepted = exp_ena;
    @(posedge CLK);
    if (rst) begin
      m_locked = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    end else if (!m_locked) begin
      w = pick_winner(want);
      if (w >= 0) begin
        m_locked = 1; m_owner = w; m_beats = 0;
      end
    end else if (exp_ena) begin
      m_beats++;
      if (m_beats == BEATS) begin
        m_locked = 0;
        m_beats  = 0;
`ifdef MIMO_ARB_PRIO0_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
      end
    end
  endtask

  task automatic do_reset();
    bit acc;
    step(1'b1, '0, '0, 1'b1, '0, acc);
    step(1'b1, '0, '0, 1'b1, '0, acc);
    grant_log.delete();
    data_log.delete();
  endtask

  task automatic check_log(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, grant_log.size(), exp_q.size());
    foreach (exp_q[i]) chk(tag, (i < grant_log.size()) ? grant_log[i] : -1, exp_q[i]);
  endtask

  initial begin
    bit             acc;
    int             beats;
    int             stall;
    int             exp_q[$];
    logic [N*W-1:0] d;
    logic [W-1:0]   a0;

    RST = 1'b1; req_want = '0; req_enq__ENA = '0; req_enq_v = '0; mimo_enq__RDY = 1'b0;
    m_locked = 0; m_owner = 0; m_beats = 0; m_ptr = 0; prev_valid = 0;

    // Single requester 2 sends one word A0..A3; all-quiet IDLE afterwards.
    do_reset();
    beats = 0;
    a0 = 32'hA0;
    for (int c = 0; c < 7; c++) begin
      d = rand_data();
      d[2*W +: W] = a0 + W'(beats);
      step(1'b0, (beats < BEATS) ? 4'b0100 : 4'b0000, '1, 1'b1, d, acc);
      beats += int'(acc);
    end
    exp_q = '{2};
    check_log("single_grant", exp_q);
    chk("single_beats", data_log.size(), BEATS);
    foreach (data_log[i]) chk("single_data", data_log[i], 32'hA0 + i);

    // All four requesting continuously: eight words in round-robin order.
    do_reset();
    for (int c = 0; c < 8 * (BEATS + 1); c++) step(1'b0, 4'b1111, '1, 1'b1, rand_data(), acc);
`ifdef MIMO_ARB_PRIO0_EN
    exp_q = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    check_log("rr_seq", exp_q);
    chk("rr_beats", data_log.size(), 8 * BEATS);

    // Owner 1 stalled by the MIMO for 5 cycles after its second beat.
    do_reset();
    beats = 0; stall = 0;
    for (int c = 0; c < 20 && beats < BEATS; c++) begin
      bit mr;
      mr = !(beats == 2 && stall < 5);
      if (!mr) stall++;
      step(1'b0, 4'b0010, '1, mr, rand_data(), acc);
      beats += int'(acc);
    end
    chk("stall_cycles", stall, 5);
    chk("stall_word_done", beats, BEATS);

    // Owner 3 drops want after beat 1: word still completes, next grant wraps to 0.
    do_reset();
    beats = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (beats >= 1) ? 4'b0011 : 4'b1000, '1, 1'b1, rand_data(), acc);
      beats += int'(acc);
    end
    exp_q = '{3, 0};
    check_log("drop_want", exp_q);

    // Reset mid-word after a completed word: pointer must restart from 0.
    do_reset();
    beats = 0;
    for (int c = 0; c < 20 && beats < BEATS + 2; c++) begin
      step(1'b0, (beats < BEATS) ? 4'b0100 : 4'b1000, '1, 1'b1, rand_data(), acc);
      beats += int'(acc);
    end
    chk("midword_beats", beats, BEATS + 2);
    step(1'b1, 4'b1100, '1, 1'b1, rand_data(), acc);
    grant_log.delete();
    prev_valid = 0;
    for (int c = 0; c < 3; c++) step(1'b0, 4'b1100, '1, 1'b1, rand_data(), acc);
    exp_q = '{2};
    check_log("rst_ptr", exp_q);

    // Random traffic with occasional resets and MIMO back-pressure.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 64) == 0, N'($urandom), N'($urandom), ($urandom % 4) != 0,
           rand_data(), acc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
